mem_access_unit: RTL and testbench

MEM-stage front end between the EX/MEM pipeline register and the word-addressed data memory.
- Converts byte-addressed load/store requests of size byte, half or word into word-index memory accesses.
- Performs sub-word stores as a 2-cycle read-modify-write (RMW), stalling upstream for the extra cycle.
- Aligns and extends load data and registers the result into the MEM/WB interface.

---
 rtl/cpu_mem_pkg.sv | 36 +++
 rtl/mem_access_unit_if.sv | 52 +++++
 rtl/mem_access_unit_load_align.sv | 48 ++++
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 tb/tb_mem_access_unit.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mem_pkg
// Shared definitions for the MEM-stage access unit: access size encodings,
// the access FSM state type, the default memory index width and the
// alignment rule shared by the datapath.
// -----------------------------------------------------------------------------
package cpu_mem_pkg;

  localparam int MEM_IDX_W_DEF = 10;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_e;

  // True when an access of the given size cannot be served at this byte
  // offset (includes the illegal size encoding).
  function automatic logic access_bad(size_e size, logic [1:0] offs);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offs[0];
      SZ_WORD: bad = |offs;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Bundles the EX/MEM request, the data-memory bus and the MEM/WB result of the
// MEM-stage access unit.
//   req_*       : request from EX/MEM (valid, read, write, size, unsigned,
//                 byte address, right-justified store data, load rd)
//   stall       : hold EX/MEM while a sub-word store reads its target word
//   mem_*       : word-indexed memory port (read/write enables, index, write
//                 data, combinational read data)
//   wb_*        : registered load result; misaligned: registered error pulse
// slave modport  : the access unit
// master modport : the pipeline/memory environment around it
// -----------------------------------------------------------------------------
interface mem_access_unit_if;

  logic        req_valid;
  logic        req_read;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        stall;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        misaligned;

  modport slave (
    input  req_valid, req_read, req_write, req_size, req_unsigned,
           req_addr, req_wdata, req_rd, mem_rdata,
    output stall, mem_read, mem_write, mem_address, mem_wdata,
           wb_valid, wb_data, wb_rd, misaligned
  );

  modport master (
    output req_valid, req_read, req_write, req_size, req_unsigned,
           req_addr, req_wdata, req_rd, mem_rdata,
    input  stall, mem_read, mem_write, mem_address, mem_wdata,
           wb_valid, wb_data, wb_rd, misaligned
  );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load aligner: picks the addressed byte/half lane(s) out of a
// memory word (little-endian) and zero- or sign-extends to 32 bits. Also
// reports which byte lanes the access covers, used for store merging.
//   word_i      : 32-bit memory word
//   addr_i      : byte offset within the word
//   size_i      : access size
//   unsigned_i  : 1 = zero-extend, 0 = sign-extend
//   data_o      : aligned, extended load data
//   lane_mask_o : one bit per byte lane touched by the access
// -----------------------------------------------------------------------------
module load_align
  import cpu_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o,
  output logic [3:0]  lane_mask_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel    = word_i[{addr_i, 3'b000} +: 8];
    half_sel    = addr_i[1] ? word_i[31:16] : word_i[15:0];
    data_o      = word_i;
    lane_mask_o = 4'b1111;
    case (size_i)
      SZ_BYTE: begin
        data_o      = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
        lane_mask_o = 4'b0001 << addr_i;
      end
      SZ_HALF: begin
        data_o      = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
        lane_mask_o = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        data_o      = word_i;
        lane_mask_o = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM-stage front end between EX/MEM and a word-addressed data memory.
// Byte-addressed loads/stores of byte/half/word size become word-index
// accesses; sub-word stores are a two-cycle read-modify-write that stalls
// EX/MEM for the read cycle; loads are aligned, extended and registered.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : mem_access_unit_if.slave (request, memory port, result)
// -----------------------------------------------------------------------------
module mem_access_unit
  import cpu_mem_pkg::*;
#(
  parameter int MEM_IDX_W = MEM_IDX_W_DEF
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);

  state_e      state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        misaligned_q, misaligned_d;

  size_e       size;
  logic        bad;
  logic        req_active;
  logic        do_load;
  logic        do_store;
  logic        sub_store;

  logic        stall;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;

  logic [31:0] load_data;
  logic [3:0]  lane_mask;
  logic [31:0] mask32;
  logic [31:0] repl_data;

  // Address bits above the memory index are deliberately dropped (wrap).
  logic        unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[31:MEM_IDX_W+2];

  assign size       = size_e'(bus.req_size);
  assign bad        = access_bad(size, bus.req_addr[1:0]);
  assign req_active = bus.req_valid & (bus.req_read | bus.req_write);
  // A store wins over a simultaneous load.
  assign do_store   = req_active & bus.req_write & ~bad;
  assign do_load    = req_active & bus.req_read & ~bus.req_write & ~bad;
  assign sub_store  = do_store & (size != SZ_WORD);

  load_align u_load_align (
    .word_i      (bus.mem_rdata),
    .addr_i      (bus.req_addr[1:0]),
    .size_i      (size),
    .unsigned_i  (bus.req_unsigned),
    .data_o      (load_data),
    .lane_mask_o (lane_mask)
  );

  // Store data replicated across all lanes so the lane mask alone selects it.
  always_comb begin
    mask32 = {{8{lane_mask[3]}}, {8{lane_mask[2]}},
              {8{lane_mask[1]}}, {8{lane_mask[0]}}};
    case (size)
      SZ_BYTE: repl_data = {4{bus.req_wdata[7:0]}};
      SZ_HALF: repl_data = {2{bus.req_wdata[15:0]}};
      default: repl_data = bus.req_wdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = bus.req_wdata;
    merge_d   = merge_q;
    case (state_q)
      IDLE: begin
        if (do_load) begin
          mem_read = 1'b1;
        end else if (sub_store) begin
          mem_read = 1'b1;
          stall    = 1'b1;
          merge_d  = (bus.mem_rdata & ~mask32) | (repl_data & mask32);
          state_d  = MERGE;
        end else if (do_store) begin
          mem_write = 1'b1;
        end
      end
      MERGE: begin
        mem_write = 1'b1;
        mem_wdata = merge_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset must kill an in-flight merge write immediately.
    if (!rst_n) begin
      stall     = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  // Results are only produced for new requests seen in IDLE; in MERGE the
  // request on the bus is the store already being completed.
  always_comb begin
    wb_valid_d   = (state_q == IDLE) & do_load;
    wb_data_d    = wb_valid_d ? load_data : wb_data_q;
    wb_rd_d      = wb_valid_d ? bus.req_rd : wb_rd_q;
    misaligned_d = (state_q == IDLE) & req_active & bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      merge_q      <= '0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= '0;
      wb_rd_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      merge_q      <= merge_d;
      wb_valid_q   <= wb_valid_d;
      wb_data_q    <= wb_data_d;
      wb_rd_q      <= wb_rd_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.stall       = stall;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.mem_address = {{(32-MEM_IDX_W){1'b0}}, bus.req_addr[MEM_IDX_W+1:2]};
  assign bus.mem_wdata   = mem_wdata;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.misaligned  = misaligned_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit with a byte-level reference model of the
// memory and per-cycle expectations of every output.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;
  import cpu_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(.MEM_IDX_W(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory attached to the DUT, and the model's own view of its contents.
  logic [31:0] sim_mem [1024];
  logic [31:0] ref_mem [1024];

  assign bus.mem_rdata = sim_mem[bus.mem_address[9:0]];
  always @(posedge clk) if (bus.mem_write) sim_mem[bus.mem_address[9:0]] <= bus.mem_wdata;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  logic        exp_stall, exp_rd, exp_wr, exp_wbv, exp_mis;
  logic [31:0] exp_addr, exp_wdata, exp_wbd;
  logic [4:0]  exp_wbrd;
  logic        nxt_wbv, nxt_mis;
  logic [31:0] nxt_wbd;
  logic [4:0]  nxt_wbrd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(bus.stall), 32'(exp_stall));
      chk("mem_read", 32'(bus.mem_read), 32'(exp_rd));
      chk("mem_write", 32'(bus.mem_write), 32'(exp_wr));
      if (exp_rd || exp_wr) chk("mem_address", bus.mem_address, exp_addr);
      if (exp_wr) chk("mem_wdata", bus.mem_wdata, exp_wdata);
      chk("wb_valid", 32'(bus.wb_valid), 32'(exp_wbv));
      chk("wb_data", bus.wb_data, exp_wbd);
      chk("wb_rd", 32'(bus.wb_rd), 32'(exp_wbrd));
      chk("misaligned", 32'(bus.misaligned), 32'(exp_mis));
    end
  end

  // Advance one clock; registered expectations from the previous cycle land.
  task automatic step();
    @(posedge clk);
    #1;
    exp_wbv = nxt_wbv;
    if (nxt_wbv) begin
      exp_wbd  = nxt_wbd;
      exp_wbrd = nxt_wbrd;
    end
    exp_mis = nxt_mis;
    nxt_wbv = 1'b0;
    nxt_mis = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
    exp_stall = 1'b0;
    exp_rd    = 1'b0;
    exp_wr    = 1'b0;
    repeat (n) step();
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] dst);
    int idx, off, nb;
    logic bad;
    logic [31:0] nw, v;
    bus.req_valid    = 1'b1;
    bus.req_read     = rd;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_rd       = dst;
    idx = int'(addr[11:2]);
    off = int'(addr[1:0]);
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    bad = (sz == 2'd3) || ((off % nb) != 0);
    exp_stall = 1'b0;
    exp_rd    = 1'b0;
    exp_wr    = 1'b0;
    exp_addr  = 32'(idx);
    exp_wdata = wd;
    if (bad) begin
      nxt_mis = 1'b1;
      step();
    end else if (wr) begin
      nw = ref_mem[idx];
      for (int b = 0; b < nb; b++) nw[8*(off+b) +: 8] = wd[8*b +: 8];
      if (nb == 4) begin
        exp_wr = 1'b1;
        step();
      end else begin
        exp_rd    = 1'b1;
        exp_stall = 1'b1;
        step();
        exp_rd    = 1'b0;
        exp_stall = 1'b0;
        exp_wr    = 1'b1;
        exp_wdata = nw;
        step();
      end
      ref_mem[idx] = nw;
    end else begin
      v = ref_mem[idx] >> (8 * off);
      if (nb == 1) v = {{24{v[7] & ~uns}}, v[7:0]};
      else if (nb == 2) v = {{16{v[15] & ~uns}}, v[15:0]};
      exp_rd   = 1'b1;
      nxt_wbv  = 1'b1;
      nxt_wbd  = v;
      nxt_wbrd = dst;
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sim_mem[i] = {16'hC0DE, 16'(i)};
      ref_mem[i] = {16'hC0DE, 16'(i)};
    end
    sim_mem[2] = 32'd3; ref_mem[2] = 32'd3;
    sim_mem[4] = 32'd5; ref_mem[4] = 32'd5;

    bus.req_valid = 1'b0; bus.req_read = 1'b0; bus.req_write = 1'b0;
    bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0;
    exp_stall = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_wbv = 1'b0; exp_mis = 1'b0;
    exp_addr = '0; exp_wdata = '0; exp_wbd = '0; exp_wbrd = '0;
    nxt_wbv = 1'b0; nxt_mis = 1'b0; nxt_wbd = '0; nxt_wbrd = '0;

    // Reset state
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Word load from 0x8
    issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 5'd7);
    chk("word_load_data", bus.wb_data, 32'h0000_0003);
    chk("word_load_rd", 32'(bus.wb_rd), 32'd7);

    // Byte store 0xAB to 0x9 (RMW)
    issue(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h9, 32'hFFFF_FFAB, 5'd0);
    chk("byte_store_mem", sim_mem[2], 32'h0000_AB03);

    // Byte loads signed / unsigned
    issue(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h9, 32'h0, 5'd3);
    chk("byte_load_signed", bus.wb_data, 32'hFFFF_FFAB);
    issue(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h9, 32'h0, 5'd4);
    chk("byte_load_unsigned", bus.wb_data, 32'h0000_00AB);

    // Misaligned half store
    issue(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h11, 32'h1234, 5'd0);
    chk("misaligned_pulse", 32'(bus.misaligned), 32'd1);
    chk("misaligned_mem", sim_mem[4], 32'd5);
    idle(1);

    // Half store 0xBEEF to 0x12 with reset pulled during MERGE
    bus.req_valid = 1'b1; bus.req_read = 1'b0; bus.req_write = 1'b1;
    bus.req_size = SZ_HALF; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h12; bus.req_wdata = 32'h0000_BEEF; bus.req_rd = 5'd0;
    exp_stall = 1'b1; exp_rd = 1'b1; exp_wr = 1'b0; exp_addr = 32'd4;
    step();
    exp_stall = 1'b0; exp_rd = 1'b0; exp_wr = 1'b1; exp_wdata = 32'hBEEF_0005;
    chk("merge_write", 32'(bus.mem_write), 32'd1);
    chk("merge_wdata", bus.mem_wdata, 32'hBEEF_0005);
    #2;
    rst_n = 1'b0;
    exp_wr = 1'b0; exp_wbv = 1'b0; exp_wbd = '0; exp_wbrd = '0; exp_mis = 1'b0;
    #1;
    chk("reset_drops_write", 32'(bus.mem_write), 32'd0);
    step();
    rst_n = 1'b1;
    chk("reset_mem_untouched", sim_mem[4], 32'd5);
    idle(1);
    issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 5'd12);
    chk("post_reset_load", bus.wb_data, 32'd5);

    // Back-to-back word store then load
    issue(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h14, 32'h77, 5'd0);
    issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, 5'd9);
    chk("b2b_load", bus.wb_data, 32'h0000_0077);

    // Upper address bits wrap; half loads on the wrapped word
    issue(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h0000_1014, 32'hCAFE_F00D, 5'd0);
    issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, 5'd1);
    chk("wrap_load", bus.wb_data, 32'hCAFE_F00D);
    issue(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h16, 32'h0, 5'd2);
    chk("half_hi_signed", bus.wb_data, 32'hFFFF_CAFE);
    issue(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h14, 32'h0, 5'd5);
    chk("half_lo_unsigned", bus.wb_data, 32'h0000_F00D);

    // Illegal size, misaligned word load
    issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 5'd6);
    chk("illegal_size", 32'(bus.misaligned), 32'd1);
    issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h22, 32'h0, 5'd6);
    chk("misaligned_word", 32'(bus.misaligned), 32'd1);

    // Read and write together: store only
    issue(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h18, 32'h0000_55AA, 5'd10);
    chk("rw_no_wb", 32'(bus.wb_valid), 32'd0);
    // Byte into lane 3, half into upper lanes of another word
    issue(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h1B, 32'h0000_009C, 5'd0);
    issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h18, 32'h0, 5'd11);
    chk("lane3_merge", bus.wb_data, 32'h9C00_55AA);
    issue(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h6, 32'h0000_8001, 5'd0);
    issue(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h6, 32'h0, 5'd13);
    chk("half_store_load", bus.wb_data, 32'hFFFF_8001);
    idle(2);

    for (int i = 0; i < 16; i++) chk($sformatf("mem_word_%0d", i), sim_mem[i], ref_mem[i]);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
